level_scroll_ctrl: RTL

//  Sequences the 10-column on-screen block array. After reset it preloads the first NUM_COLS

---
 rtl/level_pkg.sv | 39 +++
 rtl/column_fetcher.sv | 61 ++++++
 rtl/level_scroll_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/level_pkg.sv
// level_pkg: shared constants and types for the level scroll controller.
//   COL_W/ROW_COUNT/ID_W  column word layout (10 rows x 3-bit block id)
//   block_id_t            block id encoding held in each 3-bit row slot
//   scroll_state_t        scroll FSM state encoding (plain constants)
//   BLOCK_PX/SCROLL_X     fine-scroll modulus and scroll threshold
package level_pkg;

  localparam int         ROW_COUNT   = 10;
  localparam int         ID_W        = 3;
  localparam int         COL_W       = ROW_COUNT * ID_W;
  localparam int         NUM_COLS    = 10;
  localparam int         LEVEL_COLS  = 212;
  localparam int         ADDR_W      = 8;
  localparam int         BLOCK_PX    = 40;
  localparam logic [9:0] SCROLL_X    = 10'd320;
  localparam int         SCROLL_STEP = 2;

  typedef enum logic [ID_W-1:0] {
    BLK_EMPTY    = 3'd0,
    BLK_BRICK    = 3'd1,
    BLK_GROUND   = 3'd2,
    BLK_QUESTION = 3'd3,
    BLK_PIPE     = 3'd4,
    BLK_USED     = 3'd5
  } block_id_t;

  typedef logic [2:0] scroll_state_t;
  localparam scroll_state_t ST_PRELOAD_REQ   = 3'd0;
  localparam scroll_state_t ST_PRELOAD_SHIFT = 3'd1;
  localparam scroll_state_t ST_RUN           = 3'd2;
  localparam scroll_state_t ST_FETCH_REQ     = 3'd3;
  localparam scroll_state_t ST_SHIFT         = 3'd4;

  // Block id stored in a given row slot of a column word.
  function automatic block_id_t col_block(input logic [COL_W-1:0] col, input int row);
    return block_id_t'(col[row*ID_W +: ID_W]);
  endfunction

endpackage

// File: rtl/column_fetcher.sv
// column_fetcher: one-outstanding-read handshake to level memory plus the
// capture register that feeds the block array.
//   Clk, Reset    clock, synchronous active-high reset
//   start_i       begin a read of addr_i (ignored while a read is pending)
//   addr_i        column address to latch on start
//   mem_req_o     request, held until the ack cycle
//   mem_addr_o    latched address, stable while mem_req_o=1
//   mem_ack_i     read complete; only honoured while mem_req_o=1
//   mem_rdata_i   column word, captured on the ack edge
//   col_data_o    last captured column (held until next capture)
//   col_valid_o   one-cycle pulse the cycle after the capture
module column_fetcher
  import level_pkg::*;
#(
  parameter int ADDR_W = level_pkg::ADDR_W,
  parameter int COL_W  = level_pkg::COL_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [COL_W-1:0]  mem_rdata_i,
  output logic [COL_W-1:0]  col_data_o,
  output logic              col_valid_o
);

  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [COL_W-1:0]  data_q;
  logic              valid_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (req_q) begin
        if (mem_ack_i) begin
          req_q   <= 1'b0;
          data_q  <= mem_rdata_i;
          valid_q <= 1'b1;
        end
      end else if (start_i) begin
        req_q  <= 1'b1;
        addr_q <= addr_i;
      end
    end
  end

  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;
  assign col_data_o  = data_q;
  assign col_valid_o = valid_q;

endmodule

// File: rtl/level_scroll_ctrl.sv
// level_scroll_ctrl: preloads the on-screen block columns, then tracks fine
// horizontal scroll and fetches one new column per full block scrolled.
//   Clk, Reset     clock, synchronous active-high reset
//   frame_tick     one-cycle pulse per frame
//   Mario_X_Pos    Mario screen X; scrolls when >= SCROLL_X
//   mem_req/addr   level memory read request / column address
//   mem_ack/rdata  read completion / column word
//   new_block_id   column to load into the block array
//   Shift          one-cycle pulse: block array shifts in new_block_id
//   fine_scroll    0..BLOCK_PX-1 pixel offset
//   scroll_event   one-cycle pulse after each frame tick that scrolled
//   preload_done   high once the initial NUM_COLS columns are shifted in
//   level_end      high when no further columns remain
// Build option: LEVEL_WRAP_EN wraps the column pointer to 0 at the end of the
// level instead of latching level_end (attract/demo loop).
module level_scroll_ctrl #(
  parameter int         NUM_COLS    = level_pkg::NUM_COLS,
  parameter int         COL_W       = level_pkg::COL_W,
  parameter int         LEVEL_COLS  = level_pkg::LEVEL_COLS,
  parameter int         ADDR_W      = level_pkg::ADDR_W,
  parameter int         BLOCK_PX    = level_pkg::BLOCK_PX,
  parameter logic [9:0] SCROLL_X    = level_pkg::SCROLL_X,
  parameter int         SCROLL_STEP = level_pkg::SCROLL_STEP
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic [9:0]        Mario_X_Pos,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [COL_W-1:0]  mem_rdata,
  output logic [COL_W-1:0]  new_block_id,
  output logic              Shift,
  output logic [5:0]        fine_scroll,
  output logic              scroll_event,
  output logic              preload_done,
  output logic              level_end
);

  import level_pkg::*;

  localparam int              CNT_W   = $clog2(NUM_COLS + 1);
  localparam logic [ADDR_W:0] END_COL = (ADDR_W+1)'(LEVEL_COLS);
  localparam logic [6:0]      STEP7   = 7'(SCROLL_STEP);
  localparam logic [6:0]      PX7     = 7'(BLOCK_PX);

  scroll_state_t   state_q, state_d;
  logic [ADDR_W:0] next_col_q, next_col_d;
  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [5:0]      fine_q, fine_d;
  logic            ev_q, ev_d;
  logic            done_q, done_d;
  logic            end_q, end_d;

  logic            fetch_start, col_valid, advance;
  logic [6:0]      fine_sum, fine_wrap;
  logic [ADDR_W:0] col_inc;

  column_fetcher #(.ADDR_W(ADDR_W), .COL_W(COL_W)) u_fetch (
    .Clk         (Clk),
    .Reset       (Reset),
    .start_i     (fetch_start),
    .addr_i      (next_col_q[ADDR_W-1:0]),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata),
    .col_data_o  (new_block_id),
    .col_valid_o (col_valid)
  );

  // Request states issue exactly one read: start only while no read is pending;
  // the ack edge moves the FSM on before start could fire again.
  assign fetch_start = ((state_q == ST_PRELOAD_REQ) || (state_q == ST_FETCH_REQ)) && !mem_req;
  assign fine_sum    = {1'b0, fine_q} + STEP7;
  assign fine_wrap   = fine_sum - PX7;
  assign col_inc     = next_col_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    next_col_d = next_col_q;
    pre_cnt_d  = pre_cnt_q;
    fine_d     = fine_q;
    ev_d       = 1'b0;
    done_d     = done_q;
    end_d      = end_q;
    advance    = 1'b0;
    case (state_q)
      ST_PRELOAD_REQ:
        if (mem_req && mem_ack) state_d = ST_PRELOAD_SHIFT;
      ST_PRELOAD_SHIFT: begin
        advance   = 1'b1;
        pre_cnt_d = pre_cnt_q + 1'b1;
        if (pre_cnt_q == CNT_W'(NUM_COLS - 1)) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end else begin
          state_d = ST_PRELOAD_REQ;
        end
      end
      ST_RUN:
        if (frame_tick && done_q && !end_q && (Mario_X_Pos >= SCROLL_X)) begin
          ev_d = 1'b1;
          if (fine_sum >= PX7) begin
            fine_d  = fine_wrap[5:0];
            state_d = ST_FETCH_REQ;
          end else begin
            fine_d = fine_sum[5:0];
          end
        end
      ST_FETCH_REQ:
        if (mem_req && mem_ack) state_d = ST_SHIFT;
      ST_SHIFT: begin
        advance = 1'b1;
        state_d = ST_RUN;
      end
      default: state_d = ST_PRELOAD_REQ;
    endcase

    // Column pointer moves on every Shift cycle; the end of the level either
    // latches level_end or wraps back to column 0.
    if (advance) begin
      if (col_inc == END_COL) begin
`ifdef LEVEL_WRAP_EN
        next_col_d = '0;
`else
        next_col_d = col_inc;
        end_d      = 1'b1;
`endif
      end else begin
        next_col_d = col_inc;
      end
    end

    if (end_q) fine_d = '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_PRELOAD_REQ;
      next_col_q <= '0;
      pre_cnt_q  <= '0;
      fine_q     <= '0;
      ev_q       <= 1'b0;
      done_q     <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_col_q <= next_col_d;
      pre_cnt_q  <= pre_cnt_d;
      fine_q     <= fine_d;
      ev_q       <= ev_d;
      done_q     <= done_d;
      end_q      <= end_d;
    end
  end

  assign Shift        = col_valid;
  assign fine_scroll  = fine_q;
  assign scroll_event = ev_q;
  assign preload_done = done_q;
  assign level_end    = end_q;

endmodule
